// File: rtl/ctrl_pipe_hazard_pkg.sv
//==============================================================================
// pipe_pkg -- shared types for the pipeline control-hazard block
// Rev 1.0
//==============================================================================
`default_nettype none

package pipe_pkg;

  localparam int         RA_W    = 5;
  localparam int         ALU_W   = 4;
  localparam logic [2:0] BR_NONE = 3'b110;

  typedef enum logic [1:0] {
    WB_PC4 = 2'b00,
    WB_ALU = 2'b01,
    WB_MEM = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_e;

  typedef struct packed {
    logic             valid;
    logic [RA_W-1:0]  rd;
    logic [RA_W-1:0]  rs1;
    logic [RA_W-1:0]  rs2;
    logic             wren;
    wb_sel_e          wb_sel;
    logic [ALU_W-1:0] alu_sel;
    logic             alu_a_sel;
    logic             alu_b_sel;
    logic [2:0]       br_type;
    logic             mem_we;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '{
    valid:     1'b0,
    rd:        '0,
    rs1:       '0,
    rs2:       '0,
    wren:      1'b0,
    wb_sel:    WB_ALU,
    alu_sel:   '0,
    alu_a_sel: 1'b0,
    alu_b_sel: 1'b0,
    br_type:   BR_NONE,
    mem_we:    1'b0
  };

  // A stage supplies a source operand only if it really writes a non-x0 register.
  function automatic logic reg_hit(input logic            valid,
                                   input logic            wren,
                                   input logic [RA_W-1:0] rd,
                                   input logic [RA_W-1:0] src);
    return valid & wren & (rd != '0) & (rd == src);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_pipe_hazard_if.sv
//==============================================================================
// ctrl_pipe_hazard_if -- decode-side control bundle in, staged controls out
// Rev 1.0
//==============================================================================
`default_nettype none

interface ctrl_pipe_hazard_if;
  import pipe_pkg::*;

  logic             id_valid;
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic [RA_W-1:0]  id_rd;
  logic             id_wren;
  logic [1:0]       id_wb_sel;
  logic [ALU_W-1:0] id_alu_sel;
  logic             id_alu_a_sel;
  logic             id_alu_b_sel;
  logic [2:0]       id_br_type;
  logic             id_mem_we;
  logic             ex_br_taken;

  logic             ex_valid;
  logic [RA_W-1:0]  ex_rd;
  logic [RA_W-1:0]  ex_rs1;
  logic [RA_W-1:0]  ex_rs2;
  logic             ex_wren;
  logic [1:0]       ex_wb_sel;
  logic [ALU_W-1:0] ex_alu_sel;
  logic             ex_alu_a_sel;
  logic             ex_alu_b_sel;
  logic [2:0]       ex_br_type;
  logic             ex_mem_we;

  logic             mem_valid;
  logic [RA_W-1:0]  mem_rd;
  logic             mem_wren;
  logic [1:0]       mem_wb_sel;
  logic             mem_we;

  logic             wb_valid;
  logic [RA_W-1:0]  wb_rd;
  logic             wb_wren;
  logic [1:0]       wb_wb_sel;

  logic             stall;
  logic             flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_wren, id_wb_sel, id_alu_sel,
           id_alu_a_sel, id_alu_b_sel, id_br_type, id_mem_we, ex_br_taken,
    input  ex_valid, ex_rd, ex_rs1, ex_rs2, ex_wren, ex_wb_sel, ex_alu_sel,
           ex_alu_a_sel, ex_alu_b_sel, ex_br_type, ex_mem_we,
           mem_valid, mem_rd, mem_wren, mem_wb_sel, mem_we,
           wb_valid, wb_rd, wb_wren, wb_wb_sel,
           stall, flush, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_wren, id_wb_sel, id_alu_sel,
           id_alu_a_sel, id_alu_b_sel, id_br_type, id_mem_we, ex_br_taken,
    output ex_valid, ex_rd, ex_rs1, ex_rs2, ex_wren, ex_wb_sel, ex_alu_sel,
           ex_alu_a_sel, ex_alu_b_sel, ex_br_type, ex_mem_we,
           mem_valid, mem_rd, mem_wren, mem_wb_sel, mem_we,
           wb_valid, wb_rd, wb_wren, wb_wb_sel,
           stall, flush, fwd_a_sel, fwd_b_sel
  );

endinterface

`default_nettype wire

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
//==============================================================================
// fwd_unit -- bypass select for one EX source operand (MEM beats WB)
// Rev 1.0
//==============================================================================
`default_nettype none

module fwd_unit
  import pipe_pkg::*;
(
  input  logic [RA_W-1:0] rs_i,
  input  logic            mem_valid_i,
  input  logic            mem_wren_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic            wb_valid_i,
  input  logic            wb_wren_i,
  input  logic [RA_W-1:0] wb_rd_i,
  output fwd_e            sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (reg_hit(mem_valid_i, mem_wren_i, mem_rd_i, rs_i)) begin
      sel_o = FWD_MEM;
    end else if (reg_hit(wb_valid_i, wb_wren_i, wb_rd_i, rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_pipe_hazard.sv
//==============================================================================
// ctrl_pipe_hazard -- ID/EX, EX/MEM, MEM/WB control registers with load-use
// stall, branch flush and forwarding selects. Rev 1.0
//==============================================================================
`default_nettype none

module ctrl_pipe_hazard
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  ctrl_pipe_hazard_if.slave bus
);

  ctrl_bundle_t ex_q,  ex_d;
  ctrl_bundle_t mem_q, mem_d;
  ctrl_bundle_t wb_q,  wb_d;
  ctrl_bundle_t id_bundle;

  logic load_use;
  logic flush;
  logic stall;
  fwd_e fwd_a;
  fwd_e fwd_b;

  always_comb begin
    id_bundle = '{
      valid:     bus.id_valid,
      rd:        bus.id_rd,
      rs1:       bus.id_rs1,
      rs2:       bus.id_rs2,
      wren:      bus.id_wren,
      wb_sel:    wb_sel_e'(bus.id_wb_sel),
      alu_sel:   bus.id_alu_sel,
      alu_a_sel: bus.id_alu_a_sel,
      alu_b_sel: bus.id_alu_b_sel,
      br_type:   bus.id_br_type,
      mem_we:    bus.id_mem_we
    };
  end

  assign flush    = ex_q.valid & bus.ex_br_taken;
  assign load_use = bus.id_valid & ex_q.valid & ex_q.wren &
                    (ex_q.wb_sel == WB_MEM) & (ex_q.rd != '0) &
                    ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));
  // A taken branch discards the dependent instruction anyway, so it never stalls.
  assign stall    = load_use & ~flush;

  always_comb begin
    ex_d  = id_bundle;
    mem_d = ex_q;
    wb_d  = mem_q;
    if (flush | stall | ~bus.id_valid) begin
      ex_d = CTRL_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= CTRL_BUBBLE;
      mem_q <= CTRL_BUBBLE;
      wb_q  <= CTRL_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  fwd_unit u_fwd_a (
    .rs_i        (ex_q.rs1),
    .mem_valid_i (mem_q.valid),
    .mem_wren_i  (mem_q.wren),
    .mem_rd_i    (mem_q.rd),
    .wb_valid_i  (wb_q.valid),
    .wb_wren_i   (wb_q.wren),
    .wb_rd_i     (wb_q.rd),
    .sel_o       (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_i        (ex_q.rs2),
    .mem_valid_i (mem_q.valid),
    .mem_wren_i  (mem_q.wren),
    .mem_rd_i    (mem_q.rd),
    .wb_valid_i  (wb_q.valid),
    .wb_wren_i   (wb_q.wren),
    .wb_rd_i     (wb_q.rd),
    .sel_o       (fwd_b)
  );

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_wren      = ex_q.wren;
  assign bus.ex_wb_sel    = ex_q.wb_sel;
  assign bus.ex_alu_sel   = ex_q.alu_sel;
  assign bus.ex_alu_a_sel = ex_q.alu_a_sel;
  assign bus.ex_alu_b_sel = ex_q.alu_b_sel;
  assign bus.ex_br_type   = ex_q.br_type;
  assign bus.ex_mem_we    = ex_q.mem_we;

  assign bus.mem_valid    = mem_q.valid;
  assign bus.mem_rd       = mem_q.rd;
  assign bus.mem_wren     = mem_q.wren;
  assign bus.mem_wb_sel   = mem_q.wb_sel;
  assign bus.mem_we       = mem_q.mem_we;

  assign bus.wb_valid     = wb_q.valid;
  assign bus.wb_rd        = wb_q.rd;
  assign bus.wb_wren      = wb_q.wren;
  assign bus.wb_wb_sel    = wb_q.wb_sel;

  assign bus.stall        = stall;
  assign bus.flush        = flush;
  assign bus.fwd_a_sel    = fwd_a;
  assign bus.fwd_b_sel    = fwd_b;

  // The write-back stage only needs rd/wren/wb_sel; the rest rides along unused.
  logic unused_wb;
  assign unused_wb = ^{wb_q.rs1, wb_q.rs2, wb_q.alu_sel, wb_q.alu_a_sel,
                       wb_q.alu_b_sel, wb_q.br_type, wb_q.mem_we};

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe_hazard.sv
//==============================================================================
// tb_ctrl_pipe_hazard -- directed cycle-by-cycle vectors for the hazard block
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_ctrl_pipe_hazard;

  localparam logic [2:0] BN  = 3'b110;
  localparam int         NV  = 21;

  typedef struct {
    logic       valid;
    logic [4:0] rs1, rs2, rd;
    logic       wren;
    logic [1:0] wb_sel;
    logic       a_sel, b_sel;
    logic [2:0] br;
    logic       mem_we;
  } instr_t;

  typedef struct {
    instr_t     ins;
    logic       br_taken;
    logic       stall, flush;
    logic [1:0] fa, fb;
    logic       exv, exw;
    logic [4:0] exrd;
    logic [2:0] exbr;
    logic       exmwe;
    logic       memv, wbv;
    logic [4:0] wbrd;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ntests = 0;
  int   nfail  = 0;
  rec_t vec [NV];

  always #5 clk = ~clk;

  ctrl_pipe_hazard_if bus ();

  ctrl_pipe_hazard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic instr_t i_add(input logic [4:0] rd, rs1, rs2);
    return '{valid:1'b1, rs1:rs1, rs2:rs2, rd:rd, wren:1'b1, wb_sel:2'b01,
             a_sel:1'b1, b_sel:1'b0, br:BN, mem_we:1'b0};
  endfunction

  function automatic instr_t i_lw(input logic [4:0] rd, rs1);
    return '{valid:1'b1, rs1:rs1, rs2:5'd0, rd:rd, wren:1'b1, wb_sel:2'b10,
             a_sel:1'b1, b_sel:1'b1, br:BN, mem_we:1'b0};
  endfunction

  function automatic instr_t i_sw(input logic [4:0] rs1, rs2, immrd);
    return '{valid:1'b1, rs1:rs1, rs2:rs2, rd:immrd, wren:1'b0, wb_sel:2'b10,
             a_sel:1'b1, b_sel:1'b1, br:BN, mem_we:1'b1};
  endfunction

  function automatic instr_t i_beq(input logic [4:0] rs1, rs2);
    return '{valid:1'b1, rs1:rs1, rs2:rs2, rd:5'd0, wren:1'b0, wb_sel:2'b01,
             a_sel:1'b1, b_sel:1'b0, br:3'b000, mem_we:1'b0};
  endfunction

  // Invalid slot carrying tempting fields: it must still become a bubble.
  function automatic instr_t i_nop();
    return '{valid:1'b0, rs1:5'd2, rs2:5'd2, rd:5'd2, wren:1'b1, wb_sel:2'b10,
             a_sel:1'b1, b_sel:1'b0, br:3'b000, mem_we:1'b1};
  endfunction

  function automatic rec_t mk(input instr_t ins, input logic bt,
                              input logic s, f, input logic [1:0] fa, fb,
                              input logic exv, exw, input logic [4:0] exrd,
                              input logic [2:0] exbr, input logic exmwe,
                              input logic memv, wbv, input logic [4:0] wbrd);
    return '{ins:ins, br_taken:bt, stall:s, flush:f, fa:fa, fb:fb, exv:exv,
             exw:exw, exrd:exrd, exbr:exbr, exmwe:exmwe, memv:memv, wbv:wbv,
             wbrd:wbrd};
  endfunction

  task automatic drive(input instr_t ins, input logic bt);
    bus.id_valid     = ins.valid;
    bus.id_rs1       = ins.rs1;
    bus.id_rs2       = ins.rs2;
    bus.id_rd        = ins.rd;
    bus.id_wren      = ins.wren;
    bus.id_wb_sel    = ins.wb_sel;
    bus.id_alu_sel   = 4'h0;
    bus.id_alu_a_sel = ins.a_sel;
    bus.id_alu_b_sel = ins.b_sel;
    bus.id_br_type   = ins.br;
    bus.id_mem_we    = ins.mem_we;
    bus.ex_br_taken  = bt;
  endtask

  task automatic chk(input string nm, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_rec(input rec_t r, input int c);
    chk("stall",      c, 32'(bus.stall),      32'(r.stall));
    chk("flush",      c, 32'(bus.flush),      32'(r.flush));
    chk("fwd_a_sel",  c, 32'(bus.fwd_a_sel),  32'(r.fa));
    chk("fwd_b_sel",  c, 32'(bus.fwd_b_sel),  32'(r.fb));
    chk("ex_valid",   c, 32'(bus.ex_valid),   32'(r.exv));
    chk("ex_wren",    c, 32'(bus.ex_wren),    32'(r.exw));
    chk("ex_rd",      c, 32'(bus.ex_rd),      32'(r.exrd));
    chk("ex_br_type", c, 32'(bus.ex_br_type), 32'(r.exbr));
    chk("ex_mem_we",  c, 32'(bus.ex_mem_we),  32'(r.exmwe));
    chk("mem_valid",  c, 32'(bus.mem_valid),  32'(r.memv));
    chk("wb_valid",   c, 32'(bus.wb_valid),   32'(r.wbv));
    chk("wb_rd",      c, 32'(bus.wb_rd),      32'(r.wbrd));
  endtask

  initial begin
    //                ID instr           bt  st fl fa fb exv exw exrd exbr  mwe memv wbv wbrd
    vec[0]  = mk(i_add(3, 1, 2),      0,  0, 0, 0, 0, 0, 0, 0,  BN,    0,  0, 0, 0);
    vec[1]  = mk(i_add(4, 3, 1),      0,  0, 0, 0, 0, 1, 1, 3,  BN,    0,  0, 0, 0);
    vec[2]  = mk(i_add(9, 3, 0),      0,  0, 0, 1, 0, 1, 1, 4,  BN,    0,  1, 0, 0);
    vec[3]  = mk(i_lw(5, 1),          0,  0, 0, 2, 0, 1, 1, 9,  BN,    0,  1, 1, 3);
    vec[4]  = mk(i_add(6, 5, 1),      0,  1, 0, 0, 0, 1, 1, 5,  BN,    0,  1, 1, 4);
    vec[5]  = mk(i_add(6, 5, 1),      0,  0, 0, 0, 0, 0, 0, 0,  BN,    0,  1, 1, 9);
    vec[6]  = mk(i_beq(1, 2),         0,  0, 0, 2, 0, 1, 1, 6,  BN,    0,  0, 1, 5);
    vec[7]  = mk(i_add(10, 1, 1),     1,  0, 1, 0, 0, 1, 0, 0,  3'b000,0,  1, 0, 0);
    vec[8]  = mk(i_lw(5, 2),          0,  0, 0, 0, 0, 0, 0, 0,  BN,    0,  1, 1, 6);
    vec[9]  = mk(i_add(11, 5, 2),     1,  0, 1, 0, 0, 1, 1, 5,  BN,    0,  0, 1, 0);
    vec[10] = mk(i_add(0, 1, 2),      0,  0, 0, 0, 0, 0, 0, 0,  BN,    0,  1, 0, 0);
    vec[11] = mk(i_add(12, 0, 0),     0,  0, 0, 0, 0, 1, 1, 0,  BN,    0,  0, 1, 5);
    vec[12] = mk(i_sw(1, 5, 5),       0,  0, 0, 0, 0, 1, 1, 12, BN,    0,  1, 0, 0);
    vec[13] = mk(i_add(13, 5, 0),     0,  0, 0, 0, 0, 1, 0, 5,  BN,    1,  1, 1, 0);
    vec[14] = mk(i_add(14, 13, 13),   0,  0, 0, 0, 0, 1, 1, 13, BN,    0,  1, 1, 12);
    vec[15] = mk(i_add(15, 13, 14),   0,  0, 0, 1, 1, 1, 1, 14, BN,    0,  1, 1, 5);
    vec[16] = mk(i_add(13, 1, 1),     0,  0, 0, 2, 1, 1, 1, 15, BN,    0,  1, 1, 13);
    vec[17] = mk(i_add(13, 1, 1),     0,  0, 0, 0, 0, 1, 1, 13, BN,    0,  1, 1, 14);
    vec[18] = mk(i_add(2, 13, 13),    0,  0, 0, 0, 0, 1, 1, 13, BN,    0,  1, 1, 15);
    vec[19] = mk(i_nop(),             0,  0, 0, 1, 1, 1, 1, 2,  BN,    0,  1, 1, 13);
    vec[20] = mk(i_nop(),             0,  0, 0, 0, 0, 0, 0, 0,  BN,    0,  1, 1, 13);

    // Reset held two cycles with a load-use-shaped instruction sitting in ID.
    drive(i_add(6, 5, 1), 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst ex_valid",   -1, 32'(bus.ex_valid),   32'd0);
    chk("rst mem_valid",  -1, 32'(bus.mem_valid),  32'd0);
    chk("rst wb_valid",   -1, 32'(bus.wb_valid),   32'd0);
    chk("rst ex_wren",    -1, 32'(bus.ex_wren),    32'd0);
    chk("rst mem_wren",   -1, 32'(bus.mem_wren),   32'd0);
    chk("rst wb_wren",    -1, 32'(bus.wb_wren),    32'd0);
    chk("rst ex_br_type", -1, 32'(bus.ex_br_type), 32'(BN));
    chk("rst ex_wb_sel",  -1, 32'(bus.ex_wb_sel),  32'd1);
    chk("rst stall",      -1, 32'(bus.stall),      32'd0);
    chk("rst flush",      -1, 32'(bus.flush),      32'd0);
    rst = 1'b0;
    drive(i_nop(), 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i].ins, vec[i].br_taken);
      #2;
      check_rec(vec[i], i);
    end

    // Reset arriving while a stall is being requested still clears every stage.
    @(negedge clk);
    drive(i_lw(5, 1), 1'b0);
    @(negedge clk);
    drive(i_add(6, 5, 1), 1'b0);
    #2;
    chk("pre-rst stall", 100, 32'(bus.stall), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("midrst ex_valid",   101, 32'(bus.ex_valid),   32'd0);
    chk("midrst mem_valid",  101, 32'(bus.mem_valid),  32'd0);
    chk("midrst wb_valid",   101, 32'(bus.wb_valid),   32'd0);
    chk("midrst stall",      101, 32'(bus.stall),      32'd0);
    chk("midrst mem_wb_sel", 101, 32'(bus.mem_wb_sel), 32'd1);
    chk("midrst ex_br_type", 101, 32'(bus.ex_br_type), 32'(BN));
    rst = 1'b0;
    drive(i_nop(), 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire
